// File: rtl/sample_rate_pkg.sv
// Shared constants and mode encoding for the multi-channel sample-rate divider.
package sample_rate_pkg;

    localparam int unsigned DEF_WIDTH        = 8;
    localparam int unsigned DEF_NUM_CH       = 4;
    localparam int unsigned DEF_RST_ROLLOVER = 2 ** DEF_WIDTH - 2;

    typedef enum logic {
        MODE_CONT    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_e;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned ch_idx_width(int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/sample_rate_divider_mc_if.sv
// Control/configuration and strobe/done bundle for sample_rate_divider_mc.
interface sample_rate_divider_mc_if
    import sample_rate_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned WIDTH  = DEF_WIDTH
);
    localparam int unsigned CH_W = ch_idx_width(NUM_CH);

    logic              en;
    logic              clear;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [WIDTH-1:0]  cfg_rollover;
    logic              cfg_oneshot;
    logic [NUM_CH-1:0] strobe;
    logic [NUM_CH-1:0] done;

    modport master (
        output en, clear, cfg_wr, cfg_ch, cfg_rollover, cfg_oneshot,
        input  strobe, done
    );

    modport slave (
        input  en, clear, cfg_wr, cfg_ch, cfg_rollover, cfg_oneshot,
        output strobe, done
    );

endinterface

// File: rtl/rate_channel.sv
// One divider channel: counts to its rollover, pulses strobe, latches done in one-shot mode.
module rate_channel
    import sample_rate_pkg::*;
#(
    parameter int unsigned      WIDTH        = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_ROLLOVER = WIDTH'(2 ** WIDTH - 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_rollover,
    input  logic             load_oneshot,
    output logic             strobe,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] rollover_q, rollover_d;
    mode_e            mode_q, mode_d;
    logic             done_q, done_d;
    logic             strobe_q, strobe_d;
    logic             active;

    // A finished one-shot stays parked until re-armed or cleared.
    assign active = en && (rollover_q != '0) && !((mode_q == MODE_ONESHOT) && done_q);

    always_comb begin
        count_d    = count_q;
        rollover_d = rollover_q;
        mode_d     = mode_q;
        done_d     = done_q;
        strobe_d   = 1'b0;
        if (clear || load) begin
            count_d = '0;
            done_d  = 1'b0;
            if (load) begin
                rollover_d = load_rollover;
                mode_d     = mode_e'(load_oneshot);
            end
        end else if (active) begin
            if (count_q == rollover_q) begin
                count_d  = '0;
                strobe_d = 1'b1;
                if (mode_q == MODE_ONESHOT) done_d = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            rollover_q <= RST_ROLLOVER;
            mode_q     <= MODE_CONT;
            done_q     <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            rollover_q <= rollover_d;
            mode_q     <= mode_d;
            done_q     <= done_d;
            strobe_q   <= strobe_d;
        end
    end

    assign strobe = strobe_q;
    assign done   = done_q;

endmodule

// File: rtl/sample_rate_divider_mc.sv
// NUM_CH independent rate dividers sharing enable/clear, with per-channel configuration writes.
module sample_rate_divider_mc
    import sample_rate_pkg::*;
#(
    parameter int unsigned NUM_CH       = DEF_NUM_CH,
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned RST_ROLLOVER = 2 ** WIDTH - 2
) (
    input logic                     clk,
    input logic                     rst,
    sample_rate_divider_mc_if.slave bus
);

    logic [NUM_CH-1:0] strobe_w;
    logic [NUM_CH-1:0] done_w;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic load;

        // Out-of-range channel numbers simply match no instance.
        assign load = bus.cfg_wr && (32'(bus.cfg_ch) == i);

        rate_channel #(
            .WIDTH        (WIDTH),
            .RST_ROLLOVER (WIDTH'(RST_ROLLOVER))
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .en            (bus.en),
            .clear         (bus.clear),
            .load          (load),
            .load_rollover (bus.cfg_rollover),
            .load_oneshot  (bus.cfg_oneshot),
            .strobe        (strobe_w[i]),
            .done          (done_w[i])
        );
    end

    assign bus.strobe = strobe_w;
    assign bus.done   = done_w;

endmodule

// File: doc/sample_rate_divider_mc.md
SAMPLE_RATE_DIVIDER_MC -- requirements
Module: sample_rate_divider_mc

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter WIDTH, default 8: counter and rollover width in bits (2..16).
REQ-003 The block SHALL have parameter RST_ROLLOVER, default 2**WIDTH-2: per-channel rollover loaded at reset.
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 The block SHALL have port en, input, 1: global count enable.
REQ-007 The block SHALL have port clear, input, 1: synchronous clear of all counters, strobes and done flags.
REQ-008 The block SHALL have port cfg_wr, input, 1: single-cycle configuration write strobe.
REQ-009 The block SHALL have port cfg_ch, input, max(1,$clog2(NUM_CH)): target channel of the write.
REQ-010 The block SHALL have port cfg_rollover, input, WIDTH: new rollover value.
REQ-011 The block SHALL have port cfg_oneshot, input, 1: new mode (1 one-shot, 0 continuous).
REQ-012 The block SHALL have port strobe, output, NUM_CH: per-channel one-cycle divide pulse, registered.
REQ-013 The block SHALL have port done, output, NUM_CH: per-channel one-shot completion flag, registered.

Function
REQ-014 Each channel SHALL hold count (WIDTH bits), rollover (WIDTH), oneshot (1) and done (1) registers.
REQ-015 A channel SHALL be active when en=1, rollover!=0, and not (oneshot=1 and done=1).
REQ-016 On an edge with the channel active and count!=rollover, the block SHALL set count to count+1 and strobe to 0.
REQ-017 On an edge with the channel active and count==rollover, the block SHALL set count to 0 and strobe to 1, and SHALL set done to 1 if oneshot=1; the period is therefore rollover+1 cycles.
REQ-018 On an edge with the channel inactive, the block SHALL hold count and set strobe to 0.
REQ-019 strobe SHALL never be high for two consecutive cycles unless rollover==1… excluded: rollover=1 SHALL give a period of 2 cycles (alternating 0/1).
REQ-020 On cfg_wr=1 with cfg_ch<NUM_CH, the target channel SHALL load rollover, oneshot, count=0, done=0 and strobe=0 on that edge (re-arm), regardless of en.
REQ-021 cfg_wr with cfg_ch>=NUM_CH SHALL be ignored.
REQ-022 clear=1 SHALL set every count, strobe and done to 0 and retain rollover/oneshot; clear SHALL take priority over counting.
REQ-023 clear=1 together with cfg_wr=1 SHALL clear all channels and also store the written rollover/oneshot.
REQ-024 A rollover of 0 SHALL idle the channel: count held at 0, strobe and done low.
REQ-025 A rollover of 2**WIDTH-1 SHALL give a period of 2**WIDTH cycles; there SHALL be no overflow path.
REQ-026 Channels SHALL be mutually independent except through en, clear and rst.

Reset
REQ-027 While rst=1, all count, strobe and done SHALL be 0, rollover SHALL be RST_ROLLOVER and oneshot SHALL be 0, asynchronously and without waiting for a clock edge.
REQ-028 Reset asserted mid-count SHALL abort that count; after release, counting SHALL restart from 0 on the first active edge.

Structure
REQ-029 A shared package sample_rate_pkg SHALL hold the default WIDTH, NUM_CH and RST_ROLLOVER constants and the mode encoding (MODE_CONT=0, MODE_ONESHOT=1).
REQ-030 A per-channel sub-module rate_channel SHALL implement REQ-014..025 for one channel; the top level SHALL instantiate NUM_CH copies and decode cfg_ch.

Verification (WIDTH=8, NUM_CH=4)
REQ-031 Reset then en=1, defaults kept -> strobe[0] first high after 255 rising edges and every 255 cycles after; done=0.
REQ-032 Write ch1 rollover=3 continuous, en=1 -> strobe[1] 1-cycle pulses every 4 cycles, exactly 3 pulses in 12 cycles; other channels unaffected.
REQ-033 Write ch2 rollover=5 one-shot -> single strobe[2] at edge 6, done[2]=1 thereafter, no pulse over next 50 cycles; rewrite ch2 -> done[2]=0, pulse again after 6 edges.
REQ-034 Write ch3 rollover=0 and run 300 cycles -> strobe[3]=0 throughout; ch0 with rollover=255 -> period 256.
REQ-035 en low for 10 cycles mid-count -> counts hold, no strobes, and the pulse arrives 10 cycles late; rst pulse mid-count -> outputs 0 immediately, rollovers back to 254.
REQ-036 clear and cfg_wr(ch1, rollover=2) on the same edge -> all counts 0, done 0, ch1 then pulses every 3 cycles.
